// File: rtl/deser8_pkg.sv
// rtl/deser8_pkg.sv - shared widths and FSM state type for the deser8 receiver
//
// Purpose : widths and FSM state encoding shared by deser8 and its demux.
// Ports   : none (package).
package deser8_pkg;

  localparam int DATA_W = 8;
  localparam int IDX_W  = 3;

  typedef enum logic {
    COLLECT = 1'b0,
    PARITY  = 1'b1
  } state_t;

endpackage

// File: rtl/deser8_demux1to8.sv
// rtl/deser8_demux1to8.sv - 3-bit select to gated 8-bit one-hot write enable
//
// Purpose : steers one serial bit into a single staging slot. This is the
//           receive-side counterpart of the serializer's 8:1 mux tree.
// Ports   : i_sel [2:0]  slot to enable
//           i_en         global enable; when low no slot is enabled
//           o_we  [7:0]  one-hot (or all-zero) write enable
module demux1to8
  import deser8_pkg::*;
(
  input  logic [IDX_W-1:0]  i_sel,
  input  logic              i_en,
  output logic [DATA_W-1:0] o_we
);

  always_comb begin
    o_we = '0;
    if (i_en) begin
      o_we = DATA_W'(1) << i_sel;
    end
  end

endmodule

// File: rtl/deser8.sv
// rtl/deser8.sv - serial-to-parallel 8-bit word receiver with valid/ready output
//
// Purpose : reassembles 8-bit words from a one-bit stream using a 3-bit bit
//           index and a 1-to-8 demux into a staging register, then hands the
//           word to a consumer with a valid/ready handshake.
//           Optional feature macro: DESER8_PARITY_EN (adds a trailing even
//           parity bit per word and the parity_err output).
// Params  : MSB_FIRST  0 = first bit lands in bit 0, 1 = first bit in bit 7
// Ports   : clk, rst           clock, asynchronous active-high reset
//           sin, sin_valid     serial bit and its qualifier
//           start              frame align: restart the word at index 0
//           pdata, pvalid      assembled word and its valid flag
//           pready             consumer accepts pdata when pvalid is high
//           overrun            one-cycle pulse: unconsumed word overwritten
//           idx                next bit index to be written (debug)
//           parity_err         parity result of the last word (parity build)
module deser8
  import deser8_pkg::*;
#(
  parameter int MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  input  logic              sin_valid,
  input  logic              start,
  output logic [DATA_W-1:0] pdata,
  output logic              pvalid,
  input  logic              pready,
  output logic              overrun,
  output logic [IDX_W-1:0]  idx
`ifdef DESER8_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic [DATA_W-1:0]   r_stage, w_stage_nxt;
  logic [DATA_W-1:0]   r_pdata;
  logic                r_pvalid, r_overrun;
  logic [IDX_W-1:0]    w_sel, w_slot;
  logic [DATA_W-1:0]   w_base, w_we, w_word;
  logic                w_wr_en, w_done;

  // start restarts the word, so the bit on that edge always goes to index 0
  assign w_sel   = start ? '0 : r_idx;
  assign w_slot  = (MSB_FIRST != 0) ? (IDX_W'(DATA_W - 1) - w_sel) : w_sel;
  // data bits are only written while collecting; the parity bit never is
  assign w_wr_en = sin_valid && (start || (r_state == COLLECT));
  assign w_base  = start ? '0 : r_stage;

  demux1to8 u_demux (
    .i_sel (w_slot),
    .i_en  (w_wr_en),
    .o_we  (w_we)
  );

  always_comb begin
    w_stage_nxt = (w_base & ~w_we) | ({DATA_W{sin}} & w_we);
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_done      = 1'b0;
    w_word      = w_stage_nxt;

    if (start) begin
      w_state_nxt = COLLECT;
      w_idx_nxt   = sin_valid ? IDX_W'(1) : '0;
    end else if (sin_valid) begin
      if (r_state == COLLECT) begin
        // wraps 7 -> 0 naturally
        w_idx_nxt = r_idx + IDX_W'(1);
        if (r_idx == IDX_W'(DATA_W - 1)) begin
`ifdef DESER8_PARITY_EN
          w_state_nxt = PARITY;
`else
          w_done      = 1'b1;
`endif
        end
      end else begin
        // parity bit: the data word is already complete in staging
        w_state_nxt = COLLECT;
        w_done      = 1'b1;
        w_word      = r_stage;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= COLLECT;
      r_idx     <= '0;
      r_stage   <= '0;
      r_pdata   <= '0;
      r_pvalid  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_stage   <= w_stage_nxt;
      r_overrun <= 1'b0;
      if (w_done) begin
        r_pdata   <= w_word;
        r_pvalid  <= 1'b1;
        // a same-edge acceptance frees the slot, so it is not an overrun
        r_overrun <= r_pvalid && !pready;
      end else if (r_pvalid && pready) begin
        r_pvalid  <= 1'b0;
      end
    end
  end

`ifdef DESER8_PARITY_EN
  logic r_parity_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity_err <= 1'b0;
    end else if (w_done) begin
      r_parity_err <= (^w_word) ^ sin;
    end
  end

  assign parity_err = r_parity_err;
`endif

  assign pdata   = r_pdata;
  assign pvalid  = r_pvalid;
  assign overrun = r_overrun;
  assign idx     = r_idx;

endmodule
